// File: rtl/ntt_pkg.sv
// Shared constants, beat tag type and zeta address helper for the NTT zeta address generator.
// Polynomial size comes from NTT_STAGE_CNT (default 8); INTT_EN enables inverse-transform addressing.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

package ntt_pkg;

   localparam int STAGE_CNT = `NTT_STAGE_CNT;
   localparam int N         = 1 << STAGE_CNT;
   localparam int ADDR_W    = $clog2(N) - 1;
   localparam int CNT_W     = STAGE_CNT - 2;
   localparam int BEAT_CNT  = 1 << CNT_W;

   typedef struct packed {
      logic             valid;
      logic             last;
      logic [CNT_W-1:0] cnt;
      logic             inverse;
   } beat_tag_t;

   // Butterfly index {cnt, lane} narrowed to the stage's group; inverse mirrors it within 2^stage.
   function automatic logic [ADDR_W-1:0] zeta_addr(input logic [CNT_W-1:0] cnt,
                                                   input logic             lane,
                                                   input int               stage,
                                                   input logic             inv);
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] g;
      logic [ADDR_W-1:0] top;
      b   = {cnt, lane};
      g   = b >> (ADDR_W - stage);
      top = ADDR_W'((1 << stage) - 1);
      return inv ? (top - g) : g;
   endfunction

endpackage

// File: rtl/ntt_tag_delay.sv
// En-gated shift register of beat tags; every tap is exposed so the top can pick any delay.
// Shared by the forward build and the INTT_EN build.
module ntt_tag_delay
   import ntt_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en_i,
   input  beat_tag_t tag_i,
   output beat_tag_t taps_o [DEPTH]
);

   beat_tag_t taps_q [DEPTH];

   always_ff @(posedge clk) begin
      // NOTE: this tag array is reset, unlike a data RAM: stale valid bits would emit phantom strobes.
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
      end else if (en_i) begin
         taps_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
      end
   end

   assign taps_o = taps_q;

endmodule

// File: rtl/ntt_zeta_addr_gen.sv
// Zeta ROM address, per-stage valid and poly_done generator for the pipelined NTT.
// Define INTT_EN to add the `inverse` input and mirrored addressing; STAGE_CNT follows NTT_STAGE_CNT.
module ntt_zeta_addr_gen
   import ntt_pkg::*;
#(
   parameter int STAGE_CNT = `NTT_STAGE_CNT,
   parameter int STAGE_LAT = 2,
   parameter int ROM_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic                 in_last,
`ifdef INTT_EN
   input  logic                 inverse,
`endif
   output logic [ADDR_W-1:0]    rom_addr [2][STAGE_CNT-1],
   output logic [STAGE_CNT-1:0] stage_valid,
   output logic                 poly_done,
   output logic                 frame_err
);

   // line[d] is the tag d enabled cycles after acceptance; line[0] is the beat being offered now.
   localparam int LINE_LEN = 2 + (STAGE_CNT - 1) * STAGE_LAT;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_err_q, frame_err_d;
   logic             accept;
   logic             inv_sel;
   beat_tag_t        in_tag;
   beat_tag_t        line [LINE_LEN];

   assign accept = en & in_valid;

`ifdef INTT_EN
   logic inv_q;

   assign inv_sel = (cnt_q == '0) ? inverse : inv_q;

   always_ff @(posedge clk) begin
      if (!rst_n)      inv_q <= 1'b0;
      else if (accept) inv_q <= inv_sel;
   end
`else
   assign inv_sel = 1'b0;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      cnt_d          = cnt_q;
      frame_err_d    = frame_err_q;
      in_tag         = '0;
      in_tag.valid   = in_valid;
      in_tag.last    = in_last;
      in_tag.cnt     = cnt_q;
      in_tag.inverse = inv_sel;
      if (accept) begin
         cnt_d = cnt_q + 1'b1;
         if (in_last != (cnt_q == CNT_MAX)) frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign line[0] = in_tag;

   // Stage 0 sits one register after acceptance; each later stage adds STAGE_LAT.
   for (genvar s = 0; s < STAGE_CNT; s++) begin : g_stage
      localparam int DEPTH = (s == 0) ? 1 : STAGE_LAT;
      localparam int BASE  = (s == 0) ? 0 : 1 + (s - 1) * STAGE_LAT;

      beat_tag_t taps [DEPTH];

      ntt_tag_delay #(.DEPTH(DEPTH)) u_delay (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (en),
         .tag_i  (line[BASE]),
         .taps_o (taps)
      );

      for (genvar i = 0; i < DEPTH; i++) begin : g_tap
         assign line[BASE + 1 + i] = taps[i];
      end

      assign stage_valid[s] = taps[DEPTH-1].valid;
   end

   // Address register loads ROM_LAT cycles before the beat reaches its stage.
   for (genvar s = 1; s < STAGE_CNT; s++) begin : g_addr
      localparam int SRC = s * STAGE_LAT - ROM_LAT;

      for (genvar k = 0; k < 2; k++) begin : g_lane
         logic [ADDR_W-1:0] addr_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               addr_q <= '0;
            end else if (en && line[SRC].valid) begin
               addr_q <= zeta_addr(line[SRC].cnt, 1'(k), s, line[SRC].inverse);
            end
         end

         assign rom_addr[k][s-1] = addr_q;
      end
   end

   assign poly_done = en & line[LINE_LEN-1].valid & line[LINE_LEN-1].last;
   assign frame_err = frame_err_q;

endmodule
